shift32_arbiter: RTL and testbench
==================================

Name: shift32_arbiter

Overview:
- Shares one SHIFT32_L barrel shifter between two requesters (port 0 and port 1) using round-robin arbitration.
- Each requester presents a 32-bit operand, a 5-bit shift amount and a direction.
- The block latches the operation, drives the shifter, registers the result and signals completion.
- Right shifts reuse the left shifter through bit reversal: Y = rev(SHIFT_L(rev(D), S)).
- Sits between the ALU/decode stage and the shared shifter resource.

Parameters:
DATA_W, 32, operand and result width; fixed by SHIFT32_L.
SHAMT_W, 5, shift amount width.
RESET_PRIO, 0, port that wins the first simultaneous request after reset.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-low reset.
REQ0  input  1  port 0 request; held with operands stable until ACK0.
D0  input  32  port 0 operand.
S0  input  5  port 0 shift amount.
DIR0  input  1  port 0 direction: 0 = left, 1 = right (logical).
ARITH0  input  1  port 0 arithmetic-right select; honoured only with SHIFT_ARB_ARITH_EN.
ACK0  output  1  port 0 request accepted this cycle.
DONE0  output  1  one-cycle pulse; Y0 is valid.
Y0  output  32  port 0 registered result.
REQ1, D1, S1, DIR1, ARITH1, ACK1, DONE1, Y1: identical to the port 0 set, for port 1.

Behaviour:
- Reset is asynchronous, active-low (RST=0). During reset:
  - state = IDLE; ACK0/1 = 0; DONE0/1 = 0; Y0/Y1 = 0.
  - Latched operands are cleared.
  - LAST (last-granted pointer) = ~RESET_PRIO.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any REQ is high, grant one port and assert its ACK combinationally in this cycle.
  - At the clock edge: latch D, S, DIR, ARITH and the grant id; set LAST = grant id; go to BUSY.
  - If no REQ is high, stay in IDLE.
- Arbitration:
  - Only one REQ high: that port wins.
  - Both high: the port != LAST wins.
  - ACK is never asserted outside IDLE. ACK0 and ACK1 are mutually exclusive.
- BUSY:
  - Shifter inputs come from the latch registers.
  - At the edge, the result is written into the Y register of the granted port only; go to DONE.
- DONE:
  - DONE of the granted port is high for exactly one cycle; next state is IDLE.
- Latency: ACK in cycle 0, DONE and valid Y in cycle 2. Throughput: one operation per 3 cycles.
- Y of a port holds its value until that port's next completion. The other port's Y is never disturbed.
- A losing REQ stays pending with no ACK and is served on the next IDLE visit, which takes at most 3 cycles.
- REQ dropped before ACK: no operation and no side effects.
- Shift rules:
  - S = 0 returns D unchanged in either direction.
  - Left shift fills with zeros; bits shifted past bit 31 are discarded.
  - Logical right shift fills with zeros.
- Reset mid-operation (BUSY or DONE): the operation is abandoned, no DONE pulse, outputs take reset values. The requester must re-present the request.

Optional Feature:
- Macro: SHIFT_ARB_ARITH_EN.
- Defined: when DIR=1 and ARITH=1, vacated upper S bits are filled with D[31], giving an arithmetic right shift. The fill mask is computed from the latched S in BUSY, so latency is unchanged.
- Undefined: ARITH0/ARITH1 are ignored and all right shifts are logical. The ports remain present, so instantiation is identical either way.

Decomposition:
- Shared header shift_arb_defs.vh holds:
  - state encodings IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1;
  - DATA_W/SHAMT_W defaults;
  - a 32-bit bit-reverse function.
- One sub-module: the existing SHIFT32_L, instantiated exactly once.

Test Plan:
- Reset: RST=0 with both REQs high -> ACK0=ACK1=0, DONE0=DONE1=0, Y0=Y1=0. Release RST -> port 0 is granted first.
- Port 0 left shift: D0=15, S0=2, DIR0=0 -> ACK0 in cycle 0, DONE0 in cycle 2, Y0=60. D0=32'h7FFFFFFF, S0=10 -> Y0=32'hFFFFFC00.
- Port 1 right shift: D1=32'h80000000, S1=31, DIR1=1 -> Y1=1. D1=200, S1=0 -> Y1=200.
- Simultaneous requests: port 0 (D=200, S=3) and port 1 (D=1, S=1) both held -> DONE0 with Y0=1600, then DONE1 three cycles later with Y1=2, ACK1 one cycle after DONE0. A repeated simultaneous pair -> port 0 is granted again. Y0 is stable throughout port 1's operation.
- Arithmetic: D=32'hF0000000, S=4, DIR=1, ARITH=1 -> 32'hFF000000 with SHIFT_ARB_ARITH_EN, 32'h0F000000 without.
- Reset mid-operation: RST=0 while in BUSY -> no DONE pulse, Y cleared to 0. After release, the re-presented request completes normally.

Source files
------------

// File: rtl/shift32_arbiter_pkg.sv
// Shared types, constants and helpers for the shift32_arbiter block and its
// shifter sub-module.
package shift32_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift32_arbiter_shift32_l.sv
// SHIFT32_L: the shared 32-bit left barrel shifter (zero fill, overflow discarded).
module shift32_l
  import shift32_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  d,
  input  logic [SHAMT_W-1:0] s,
  output logic [DATA_W-1:0]  y
);

  assign y = d << s;

endmodule

// File: rtl/shift32_arbiter.sv
// Round-robin arbiter sharing one SHIFT32_L between two requesters; right shifts
// go through bit reversal. Define SHIFT_ARB_ARITH_EN to honour the arith inputs.
module shift32_arbiter
  import shift32_arbiter_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [DATA_W-1:0]  d0,
  input  logic [SHAMT_W-1:0] s0,
  input  logic               dir0,
  input  logic               arith0,
  output logic               ack0,
  output logic               done0,
  output logic [DATA_W-1:0]  y0,
  input  logic               req1,
  input  logic [DATA_W-1:0]  d1,
  input  logic [SHAMT_W-1:0] s1,
  input  logic               dir1,
  input  logic               arith1,
  output logic               ack1,
  output logic               done1,
  output logic [DATA_W-1:0]  y1
);

  state_t             state, state_nxt;
  logic               last, gnt;
  logic [DATA_W-1:0]  lat_d;
  logic [SHAMT_W-1:0] lat_s;
  logic               lat_dir, lat_arith;
  logic               any_req, win, arith_sel;
  logic [DATA_W-1:0]  sh_in, sh_out, fill, result;

  assign any_req = req0 | req1;
  // On contention the port that was not served last wins; otherwise the lone requester.
  assign win = (req0 & req1) ? ~last : req1;

`ifdef SHIFT_ARB_ARITH_EN
  assign arith_sel = win ? arith1 : arith0;
`else
  logic unused_arith;
  assign arith_sel    = 1'b0;
  assign unused_arith = arith0 ^ arith1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    unique case (state)
      IDLE: if (any_req) begin
        state_nxt = BUSY;
        // Gated by rst_n so a request held through reset is never acknowledged.
        ack0 = rst_n & ~win;
        ack1 = rst_n & win;
      end
      BUSY: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        done0     = ~gnt;
        done1     = gnt;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand latch is reset too, so an abandoned operation leaves
      // no stale operands behind.
      last      <= ~RESET_PRIO;
      gnt       <= 1'b0;
      lat_d     <= '0;
      lat_s     <= '0;
      lat_dir   <= DIR_LEFT;
      lat_arith <= 1'b0;
      y0        <= '0;
      y1        <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last      <= win;
        gnt       <= win;
        lat_d     <= win ? d1 : d0;
        lat_s     <= win ? s1 : s0;
        lat_dir   <= win ? dir1 : dir0;
        lat_arith <= arith_sel;
      end
      if (state == BUSY) begin
        if (gnt) y1 <= result;
        else     y0 <= result;
      end
    end
  end

  assign sh_in = (lat_dir == DIR_LEFT) ? lat_d : bit_rev(lat_d);

  shift32_l u_shift (
    .d (sh_in),
    .s (lat_s),
    .y (sh_out)
  );

  // Sign fill covers the top lat_s bits; constant zero when arith is disabled.
  assign fill = (lat_dir == DIR_RIGHT && lat_arith && lat_d[DATA_W-1]) ?
                ~({DATA_W{1'b1}} >> lat_s) : '0;
  assign result = ((lat_dir == DIR_LEFT) ? sh_out : bit_rev(sh_out)) | fill;

endmodule

// File: tb/tb_shift32_arbiter.sv
// Self-checking bench for shift32_arbiter: directed cases plus randomized
// operations checked cycle by cycle against a transaction-level reference.
module tb_shift32_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, dir0, arith0, ack0, done0;
  logic        req1, dir1, arith1, ack1, done1;
  logic [31:0] d0, d1, y0, y1;
  logic [4:0]  s0, s1;

  int          n_cmp = 0;
  int          n_err = 0;

  // Reference state: last served port and each port's current result.
  bit          m_last = 1'b1;
  logic [31:0] m_y0 = '0;
  logic [31:0] m_y1 = '0;

  always #5 clk = ~clk;

  shift32_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .d0     (d0),
    .s0     (s0),
    .dir0   (dir0),
    .arith0 (arith0),
    .ack0   (ack0),
    .done0  (done0),
    .y0     (y0),
    .req1   (req1),
    .d1     (d1),
    .s1     (s1),
    .dir1   (dir1),
    .arith1 (arith1),
    .ack1   (ack1),
    .done1  (done1),
    .y1     (y1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input bit dir, input bit ar);
    bit arith_on;
    arith_on = 1'b0;
`ifdef SHIFT_ARB_ARITH_EN
    arith_on = 1'b1;
`endif
    if (!dir) return d << s;
    if (dir && ar && arith_on) return 32'($signed(d) >>> s);
    return d >> s;
  endfunction

  // Presents one or two requests at the current cycle (called at posedge+1) and
  // checks ack/done/y on every cycle of the expected schedule plus one idle cycle.
  task automatic run_op(input bit r0, input logic [31:0] a0, input logic [4:0] sa0,
                        input bit di0, input bit ar0,
                        input bit r1, input logic [31:0] a1, input logic [4:0] sa1,
                        input bit di1, input bit ar1);
    logic [31:0] e0, e1;
    int          ac0, ac1, dc0, dc1, last_c;
    bit          first;
    e0    = ref_shift(a0, sa0, di0, ar0);
    e1    = ref_shift(a1, sa1, di1, ar1);
    first = (r0 && r1) ? ~m_last : r1;
    ac0   = -10;
    ac1   = -10;
    if (r0 && r1) begin
      if (!first) begin ac0 = 0; ac1 = 3; end
      else        begin ac1 = 0; ac0 = 3; end
    end else if (r0) ac0 = 0;
    else             ac1 = 0;
    dc0    = ac0 + 2;
    dc1    = ac1 + 2;
    last_c = (r0 && r1) ? 5 : 2;
    req0 = r0; d0 = a0; s0 = sa0; dir0 = di0; arith0 = ar0;
    req1 = r1; d1 = a1; s1 = sa1; dir1 = di1; arith1 = ar1;
    for (int c = 0; c <= last_c + 1; c++) begin
      @(negedge clk);
      check("ack0",  32'(ack0),  32'(r0 && c == ac0));
      check("ack1",  32'(ack1),  32'(r1 && c == ac1));
      check("done0", 32'(done0), 32'(r0 && c == dc0));
      check("done1", 32'(done1), 32'(r1 && c == dc1));
      check("y0", y0, (r0 && c >= dc0) ? e0 : m_y0);
      check("y1", y1, (r1 && c >= dc1) ? e1 : m_y1);
      @(posedge clk); #1;
      // Requester drops its request after ACK and scrambles operands to prove they were latched.
      if (r0 && c == ac0) begin req0 = 1'b0; d0 = $urandom; s0 = 5'($urandom); dir0 = 1'($urandom); end
      if (r1 && c == ac1) begin req1 = 1'b0; d1 = $urandom; s1 = 5'($urandom); dir1 = 1'($urandom); end
    end
    if (r0) m_y0 = e0;
    if (r1) m_y1 = e1;
    m_last = (r0 && r1) ? ~first : first;
  endtask

  initial begin
    bit   rr0, rr1;
    int   sel;

    // Reset held with both requests high: nothing may be acknowledged.
    rst_n = 1'b0;
    req0 = 1'b1; d0 = 32'd200; s0 = 5'd3; dir0 = 1'b0; arith0 = 1'b0;
    req1 = 1'b1; d1 = 32'd1;   s1 = 5'd1; dir1 = 1'b0; arith1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ack0",  32'(ack0),  32'd0);
      check("rst_ack1",  32'(ack1),  32'd0);
      check("rst_done0", 32'(done0), 32'd0);
      check("rst_done1", 32'(done1), 32'd0);
      check("rst_y0", y0, 32'd0);
      check("rst_y1", y1, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First contention after reset goes to port 0, then port 1; repeated pair -> port 0 again.
    run_op(1'b1, 32'd200, 5'd3, 1'b0, 1'b0, 1'b1, 32'd1, 5'd1, 1'b0, 1'b0);
    run_op(1'b1, 32'd200, 5'd3, 1'b0, 1'b0, 1'b1, 32'd1, 5'd1, 1'b0, 1'b0);

    // Port 0 left shifts, port 1 right shifts, S=0 passthrough.
    run_op(1'b1, 32'd15, 5'd2, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_op(1'b1, 32'h7FFF_FFFF, 5'd10, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    run_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'd200, 5'd0, 1'b1, 1'b0);
    run_op(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Arithmetic right shift request (result depends on the build).
    run_op(1'b1, 32'hF000_0000, 5'd4, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    run_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 5'd4, 1'b1, 1'b1);

    // Randomized mix of single and contending requests.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      rr0 = (sel != 1);
      rr1 = (sel != 0);
      run_op(rr0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             rr1, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
    end

    // Make both results non-zero, then reset while port 0's operation is in BUSY.
    run_op(1'b1, 32'd15, 5'd2, 1'b0, 1'b0, 1'b1, 32'd9, 5'd1, 1'b0, 1'b0);
    req0 = 1'b1; d0 = 32'h0000_00FF; s0 = 5'd4; dir0 = 1'b0; arith0 = 1'b0;
    @(negedge clk);
    check("mid_ack0", 32'(ack0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_done0", 32'(done0), 32'd0);
      check("mid_done1", 32'(done1), 32'd0);
      check("mid_y0", y0, 32'd0);
      check("mid_y1", y1, 32'd0);
      @(posedge clk); #1;
    end
    rst_n  = 1'b1;
    m_y0   = '0;
    m_y1   = '0;
    m_last = 1'b1;
    run_op(1'b1, 32'h0000_00FF, 5'd4, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_op(1'b1, 32'd5, 5'd1, 1'b0, 1'b0, 1'b1, 32'd6, 5'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
